lsm_seq: RTL and testbench

//  Multi-cycle sequencer for LDM/STM/PUSH/POP in the stage-two datapath. Walks a 16-bit register

---
 rtl/lsm_seq_pkg.sv | 16 +
 rtl/lsm_seq_prio_enc.sv | 23 ++
 rtl/lsm_seq.sv | 148 ++++++++++++++
 tb/tb_lsm_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_seq_pkg.sv
// Shared definitions for the load/store-multiple sequencer.
// FSM encodings, writeback-select codes and the word size.
package lsm_seq_pkg;

    typedef enum logic [1:0] {
        LSM_IDLE  = 2'd0,
        LSM_XFER  = 2'd1,
        LSM_WBACK = 2'd2
    } lsm_state_e;

    localparam logic WSEL_MEM = 1'b0;
    localparam logic WSEL_WB  = 1'b1;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/lsm_seq_prio_enc.sv
// Register-list priority encoder: lowest set index and popcount.
// Purely combinational.
module lsm_seq_prio_enc #(
    parameter int NREG = 16
) (
    input  logic [NREG-1:0] list_i,
    output logic [3:0]      idx_o,
    output logic [4:0]      cnt_o
);

    // Scan high to low so the lowest set bit is the last writer.
    always_comb begin
        idx_o = '0;
        cnt_o = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (list_i[i]) begin
                idx_o = 4'(i);
            end
            cnt_o = cnt_o + 5'(list_i[i]);
        end
    end

endmodule

// File: rtl/lsm_seq.sv
// LDM/STM/PUSH/POP sequencer: one memory beat per listed register.
// Define LSM_DB_EN to honour dec_before (decrement-before addressing).
module lsm_seq
    import lsm_seq_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              dec_before,
    input  logic              wback,
    input  logic [NREG-1:0]   reg_list,
    input  logic [3:0]        base_reg,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        rf_addr,
    output logic              rf_w_en,
    output logic              rf_wsel,
    output logic [ADDR_W-1:0] wb_value
);

    lsm_state_e        state_q;
    logic [NREG-1:0]   list_q;
    logic              load_q;
    logic [3:0]        base_q;
    logic              wb_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_q;
    logic              done_q;
    logic              err_q;

    logic [NREG-1:0]   enc_list;
    logic [3:0]        enc_idx;
    logic [4:0]        enc_cnt;
    logic [ADDR_W-1:0] span;
    logic [NREG-1:0]   list_d;
    logic              use_db;
    logic              bad_req;
    logic              wb_hit;

    // In IDLE the encoder sees the incoming list so its count sizes the span.
    assign enc_list = (state_q == LSM_IDLE) ? reg_list : list_q;

    lsm_seq_prio_enc #(.NREG(NREG)) u_enc (
        .list_i (enc_list),
        .idx_o  (enc_idx),
        .cnt_o  (enc_cnt)
    );

    assign span   = ADDR_W'(enc_cnt) * ADDR_W'(WORD_BYTES);
    assign list_d = list_q & (list_q - NREG'(1));
    assign wb_hit = is_load && reg_list[base_reg];

`ifdef LSM_DB_EN
    assign use_db  = dec_before;
    assign bad_req = (reg_list == '0);
`else
    assign use_db  = 1'b0;
    assign bad_req = (reg_list == '0) || dec_before;
`endif

    // Sequencer FSM: launch, walk the list one beat per ack, optional writeback.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LSM_IDLE;
            list_q  <= '0;
            load_q  <= 1'b0;
            base_q  <= '0;
            wb_en_q <= 1'b0;
            addr_q  <= '0;
            wb_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                LSM_IDLE: begin
                    if (start) begin
                        if (bad_req) begin
                            err_q <= 1'b1;
                        end else begin
                            list_q  <= reg_list;
                            load_q  <= is_load;
                            base_q  <= base_reg;
                            wb_en_q <= wback && !wb_hit;
                            addr_q  <= use_db ? base_addr - span : base_addr;
                            wb_q    <= use_db ? base_addr - span
                                              : base_addr + span;
                            state_q <= LSM_XFER;
                        end
                    end
                end
                LSM_XFER: begin
                    if (mem_ack) begin
                        list_q <= list_d;
                        addr_q <= addr_q + ADDR_W'(WORD_BYTES);
                        if (list_d == '0) begin
                            if (wb_en_q) begin
                                state_q <= LSM_WBACK;
                            end else begin
                                state_q <= LSM_IDLE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                end
                LSM_WBACK: begin
                    state_q <= LSM_IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= LSM_IDLE;
            endcase
        end
    end

    // Port drives decoded from the registered state; load strobe follows ack.
    always_comb begin
        busy     = (state_q != LSM_IDLE);
        mem_req  = (state_q == LSM_XFER);
        mem_we   = mem_req && !load_q;
        mem_addr = mem_req ? addr_q : '0;
        rf_addr  = '0;
        rf_wsel  = WSEL_MEM;
        rf_w_en  = mem_req && load_q && mem_ack;
        if (state_q == LSM_XFER) begin
            rf_addr = enc_idx;
        end
        if (state_q == LSM_WBACK) begin
            rf_addr = base_q;
            rf_wsel = WSEL_WB;
            rf_w_en = 1'b1;
        end
        done     = done_q;
        err      = err_q;
        wb_value = wb_q;
    end

endmodule

// File: tb/tb_lsm_seq.sv
// Self-checking bench for lsm_seq: vector table plus beat scoreboard.
// Expectations adapt to LSM_DB_EN.
module tb_lsm_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic        dec_before;
    logic        wback;
    logic [15:0] reg_list;
    logic [3:0]  base_reg;
    logic [31:0] base_addr;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  rf_addr;
    logic        rf_w_en;
    logic        rf_wsel;
    logic [31:0] wb_value;

    always #5 clk = ~clk;

    lsm_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_load    (is_load),
        .dec_before (dec_before),
        .wback      (wback),
        .reg_list   (reg_list),
        .base_reg   (base_reg),
        .base_addr  (base_addr),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .rf_addr    (rf_addr),
        .rf_w_en    (rf_w_en),
        .rf_wsel    (rf_wsel),
        .wb_value   (wb_value)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rf;
        logic        we;
    } beat_t;

    typedef struct {
        logic        ld;
        logic        db;
        logic        wb;
        logic [15:0] list;
        logic [3:0]  breg;
        logic [31:0] base;
        int          waits;
        logic        poke;
        logic        exp_err;
        logic        exp_wb;
        logic [31:0] exp_wbv;
    } vec_t;

    beat_t q[$];
    vec_t  tv[9];
    int    total  = 0;
    int    passed = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic ld, input logic db,
                                input logic wb, input logic [15:0] list,
                                input logic [3:0] breg,
                                input logic [31:0] base, input int waits,
                                input logic poke, input logic exp_err,
                                input logic exp_wb,
                                input logic [31:0] exp_wbv);
        vec_t v;
        v.ld = ld; v.db = db; v.wb = wb; v.list = list;
        v.breg = breg; v.base = base; v.waits = waits;
        v.poke = poke; v.exp_err = exp_err;
        v.exp_wb = exp_wb; v.exp_wbv = exp_wbv;
        return v;
    endfunction

    task automatic run(input vec_t v);
        beat_t       b;
        int          n;
        int          cyc;
        int          w;
        int          guard;
        logic [31:0] a;
        n = 0;
        for (int i = 0; i < 16; i++) if (v.list[i]) n++;
        a = v.db ? v.base - 32'(4 * n) : v.base;
        q.delete();
        if (!v.exp_err) begin
            for (int i = 0; i < 16; i++) begin
                if (v.list[i]) begin
                    b.addr = a; b.rf = 4'(i); b.we = ~v.ld;
                    q.push_back(b);
                    a = a + 32'd4;
                end
            end
        end
        start = 1'b1; is_load = v.ld; dec_before = v.db;
        wback = v.wb; reg_list = v.list; base_reg = v.breg;
        base_addr = v.base; mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        #1;
        if (v.exp_err) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_busy", {31'd0, busy}, 32'd0);
            chk("err_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk); #1;
            chk("err_clear", {31'd0, err}, 32'd0);
            chk("err_req2", {31'd0, mem_req}, 32'd0);
            chk("err_busy2", {31'd0, busy}, 32'd0);
            return;
        end
        w = 0;
        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            guard++;
            if (v.poke && cyc == 1) begin
                start = 1'b1; reg_list = 16'h00F0; is_load = ~v.ld;
            end else begin
                start = 1'b0; reg_list = v.list; is_load = v.ld;
            end
            mem_ack = (w >= v.waits);
            #1;
            b = q[0];
            chk("req", {31'd0, mem_req}, 32'd1);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("addr", mem_addr, b.addr);
            chk("rf_addr", {28'd0, rf_addr}, {28'd0, b.rf});
            chk("we", {31'd0, mem_we}, {31'd0, b.we});
            if (mem_ack) begin
                chk("rf_w_en_ack", {31'd0, rf_w_en}, {31'd0, v.ld});
                chk("wsel_mem", {31'd0, rf_wsel}, 32'd0);
                void'(q.pop_front());
                w = 0;
            end else begin
                chk("rf_w_en_wait", {31'd0, rf_w_en}, 32'd0);
                w++;
            end
            @(negedge clk);
            cyc++;
        end
        mem_ack = 1'b0; start = 1'b0;
        chk("beats_left", q.size(), 32'd0);
        #1;
        if (v.exp_wb) begin
            chk("wb_wen", {31'd0, rf_w_en}, 32'd1);
            chk("wb_wsel", {31'd0, rf_wsel}, 32'd1);
            chk("wb_rf", {28'd0, rf_addr}, {28'd0, v.breg});
            chk("wb_val", wb_value, v.exp_wbv);
            chk("wb_req", {31'd0, mem_req}, 32'd0);
            chk("wb_done_early", {31'd0, done}, 32'd0);
            @(negedge clk); #1;
            cyc++;
        end
        chk("done", {31'd0, done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_wen", {31'd0, rf_w_en}, 32'd0);
        chk("latency", cyc, 32'(n * (v.waits + 1) + (v.exp_wb ? 2 : 1)));
        mem_ack = 1'b1;
        @(negedge clk); #1;
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_wen", {31'd0, rf_w_en}, 32'd0);
        mem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0] = mk(0, 0, 0, 16'h0013, 4'd0, 32'h1000, 0, 0, 0, 0, 32'h0);
        tv[1] = mk(1, 0, 1, 16'h8001, 4'd13, 32'h2000, 2, 0, 0, 1,
                   32'h2008);
`ifdef LSM_DB_EN
        tv[2] = mk(0, 1, 1, 16'h4010, 4'd13, 32'h3000, 0, 0, 0, 1,
                   32'h2FF8);
        tv[8] = mk(1, 1, 1, 16'h0101, 4'd10, 32'h40, 1, 0, 0, 1,
                   32'h38);
`else
        tv[2] = mk(0, 1, 1, 16'h4010, 4'd13, 32'h3000, 0, 0, 1, 0,
                   32'h0);
        tv[8] = mk(1, 1, 1, 16'h0101, 4'd10, 32'h40, 1, 0, 1, 0,
                   32'h0);
`endif
        tv[3] = mk(1, 0, 1, 16'h0000, 4'd1, 32'h5000, 0, 0, 1, 0, 32'h0);
        tv[4] = mk(1, 0, 1, 16'h0004, 4'd2, 32'h4000, 0, 0, 0, 0, 32'h0);
        tv[5] = mk(0, 0, 1, 16'h0003, 4'd5, 32'hFFFFFFFC, 0, 0, 0, 1,
                   32'h4);
        tv[6] = mk(0, 0, 1, 16'hFFFF, 4'd3, 32'h100, 0, 0, 0, 1,
                   32'h140);
        tv[7] = mk(1, 0, 0, 16'h0006, 4'd0, 32'h800, 1, 1, 0, 0, 32'h0);

        rst = 1'b0; start = 1'b0; is_load = 1'b0; dec_before = 1'b0;
        wback = 1'b0; reg_list = '0; base_reg = '0; base_addr = '0;
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wbv", wb_value, 32'd0);
        chk("rst_rf", {28'd0, rf_addr}, 32'd0);
        chk("rst_wen", {31'd0, rf_w_en}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run(tv[i]);

        start = 1'b1; is_load = 1'b0; dec_before = 1'b0; wback = 1'b1;
        reg_list = 16'h00FF; base_reg = 4'd9; base_addr = 32'h500;
        mem_ack = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk); #1;
        chk("mid_busy", {31'd0, busy}, 32'd1);
        chk("mid_addr", mem_addr, 32'h500);
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_wbv", wb_value, 32'd0);
        chk("arst_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("post_done", {31'd0, done}, 32'd0);
            chk("post_err", {31'd0, err}, 32'd0);
            chk("post_busy", {31'd0, busy}, 32'd0);
        end
        run(tv[0]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
